// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared match-state encoding, field geometry and match defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_POINT  = 3'd4,
        ST_OVER   = 3'd5
    } match_state_e;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int PADDLE_W      = 8;
    localparam int PADDLE_H      = 64;
    localparam int PADDLE_MARGIN = 16;
    localparam int BALL_SIZE     = 8;

    localparam int DEF_WIN_SCORE    = 11;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int CNT_W            = 8;

endpackage

`default_nettype wire

// File: rtl/pong_match_ctrl_serve_timer.sv
// ============================================================================
// serve_timer : 8-bit frame-tick down-counter with load and expiry flag
// Rev 1.0
// ============================================================================
`default_nettype none

module serve_timer
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Flags the tick that takes the counter from 1 to 0, so the caller can
    // change state on the same edge the count reaches zero.
    assign done_o  = tick_i && (count_q == CNT_W'(1));
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ============================================================================
// pong_match_ctrl : match sequencer (serve countdown, scoring, win, pause)
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SCORE_W      = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               left_point,
    input  logic               right_point,
    output logic               field_reset,
    output logic               motion_en,
    output logic               serve_right,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               winner_l,
    output logic               winner_r,
    output logic [7:0]         countdown,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);

    match_state_e       state_q;
    logic [SCORE_W-1:0] score_l_q;
    logic [SCORE_W-1:0] score_r_q;
    logic               winner_l_q;
    logic               winner_r_q;
    logic               serve_right_q;
    logic               field_reset_q;
    logic               motion_en_q;

    logic               timer_load;
    logic               timer_tick;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_count;

    // Countdown reloads on every entry into SERVE.
    always_comb begin
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE,
            ST_OVER:  timer_load = start;
            ST_PLAY:  timer_load = left_point && right_point;
            ST_POINT: timer_load = (score_l_q != WIN_S) && (score_r_q != WIN_S);
            default:  timer_load = 1'b0;
        endcase
    end

    assign timer_tick = frame_tick && (state_q == ST_SERVE);

    serve_timer u_serve_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .load_val_i (SERVE_LOAD),
        .tick_i     (timer_tick),
        .count_o    (timer_count),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            score_l_q     <= '0;
            score_r_q     <= '0;
            winner_l_q    <= 1'b0;
            winner_r_q    <= 1'b0;
            serve_right_q <= 1'b1;
            field_reset_q <= 1'b1;
            motion_en_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE,
                ST_OVER: begin
                    if (start) begin
                        score_l_q     <= '0;
                        score_r_q     <= '0;
                        winner_l_q    <= 1'b0;
                        winner_r_q    <= 1'b0;
                        serve_right_q <= 1'b1;
                        state_q       <= ST_SERVE;
                        field_reset_q <= 1'b1;
                        motion_en_q   <= 1'b0;
                    end
                end

                ST_SERVE: begin
                    if (timer_done) begin
                        state_q       <= ST_PLAY;
                        field_reset_q <= 1'b0;
                        motion_en_q   <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (left_point && right_point) begin
                        state_q       <= ST_SERVE;
                        field_reset_q <= 1'b1;
                        motion_en_q   <= 1'b0;
                    end else if (left_point) begin
                        if (score_l_q != WIN_S) begin
                            score_l_q <= score_l_q + 1'b1;
                        end
                        serve_right_q <= 1'b1;
                        state_q       <= ST_POINT;
                        field_reset_q <= 1'b1;
                        motion_en_q   <= 1'b0;
                    end else if (right_point) begin
                        if (score_r_q != WIN_S) begin
                            score_r_q <= score_r_q + 1'b1;
                        end
                        serve_right_q <= 1'b0;
                        state_q       <= ST_POINT;
                        field_reset_q <= 1'b1;
                        motion_en_q   <= 1'b0;
                    end else if (pause) begin
                        state_q       <= ST_PAUSED;
                        field_reset_q <= 1'b0;
                        motion_en_q   <= 1'b0;
                    end
                end

                ST_PAUSED: begin
                    if (!pause) begin
                        state_q       <= ST_PLAY;
                        field_reset_q <= 1'b0;
                        motion_en_q   <= 1'b1;
                    end
                end

                ST_POINT: begin
                    // Only the player who just scored can be sitting at WIN_S.
                    if (score_l_q == WIN_S) begin
                        winner_l_q <= 1'b1;
                        state_q    <= ST_OVER;
                    end else if (score_r_q == WIN_S) begin
                        winner_r_q <= 1'b1;
                        state_q    <= ST_OVER;
                    end else begin
                        state_q    <= ST_SERVE;
                    end
                    field_reset_q <= 1'b1;
                    motion_en_q   <= 1'b0;
                end

                default: begin
                    state_q       <= ST_IDLE;
                    field_reset_q <= 1'b1;
                    motion_en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign field_reset = field_reset_q;
    assign motion_en   = motion_en_q;
    assign serve_right = serve_right_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign winner_l    = winner_l_q;
    assign winner_r    = winner_r_q;
    assign countdown   = timer_count;
    assign state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ============================================================================
// tb_pong_match_ctrl : directed + randomized bench against a match-rules model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pong_match_ctrl;

    localparam int SF  = 3;
    localparam int WIN = 2;
    localparam int SW  = 7;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSED = 3, M_POINT = 4, M_OVER = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_tick, start, pause, left_point, right_point;
    logic          field_reset, motion_en, serve_right, winner_l, winner_r;
    logic [SW-1:0] score_l, score_r;
    logic [7:0]    countdown;
    logic [2:0]    state_o;

    int checks = 0;
    int errors = 0;

    int m_state, m_sl, m_sr, m_cd;
    bit m_wl, m_wr, m_sv;

    pong_match_ctrl #(
        .SERVE_FRAMES (SF),
        .WIN_SCORE    (WIN),
        .SCORE_W      (SW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .pause       (pause),
        .left_point  (left_point),
        .right_point (right_point),
        .field_reset (field_reset),
        .motion_en   (motion_en),
        .serve_right (serve_right),
        .score_l     (score_l),
        .score_r     (score_r),
        .winner_l    (winner_l),
        .winner_r    (winner_r),
        .countdown   (countdown),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_sl = 0; m_sr = 0; m_wl = 0; m_wr = 0; m_sv = 1; m_cd = 0;
    endtask

    task automatic new_match();
        m_sl = 0; m_sr = 0; m_wl = 0; m_wr = 0; m_sv = 1; m_cd = SF; m_state = M_SERVE;
    endtask

    // Match rules, one clock edge at a time.
    task automatic model_step(input bit st, input bit ps, input bit lp, input bit rp, input bit ft);
        case (m_state)
            M_IDLE, M_OVER: if (st) new_match();
            M_SERVE: if (ft) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_state = M_PLAY;
            end
            M_PLAY: begin
                if (lp && rp) begin
                    m_cd = SF; m_state = M_SERVE;
                end else if (lp) begin
                    m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_sv = 1; m_state = M_POINT;
                end else if (rp) begin
                    m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_sv = 0; m_state = M_POINT;
                end else if (ps) begin
                    m_state = M_PAUSED;
                end
            end
            M_PAUSED: if (!ps) m_state = M_PLAY;
            M_POINT: begin
                if (m_sl == WIN) begin
                    m_wl = 1; m_state = M_OVER;
                end else if (m_sr == WIN) begin
                    m_wr = 1; m_state = M_OVER;
                end else begin
                    m_cd = SF; m_state = M_SERVE;
                end
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        bit exp_fr;
        exp_fr = !(m_state == M_PLAY || m_state == M_PAUSED);
        chk("state",       32'(state_o),     32'(m_state));
        chk("score_l",     32'(score_l),     32'(m_sl));
        chk("score_r",     32'(score_r),     32'(m_sr));
        chk("winner_l",    32'(winner_l),    32'(m_wl));
        chk("winner_r",    32'(winner_r),    32'(m_wr));
        chk("serve_right", 32'(serve_right), 32'(m_sv));
        chk("countdown",   32'(countdown),   32'(m_cd));
        chk("field_reset", 32'(field_reset), 32'(exp_fr));
        chk("motion_en",   32'(motion_en),   32'(m_state == M_PLAY));
    endtask

    task automatic cycle(input bit st, input bit ps, input bit lp, input bit rp, input bit ft);
        start = st; pause = ps; left_point = lp; right_point = rp; frame_tick = ft;
        @(posedge clk);
        model_step(st, ps, lp, rp, ft);
        #1;
        check_all();
        start = 0; left_point = 0; right_point = 0; frame_tick = 0;
    endtask

    task automatic tick();
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic release_ball();
        repeat (SF) tick();
    endtask

    initial begin
        reset_n = 0; start = 0; pause = 0; left_point = 0; right_point = 0; frame_tick = 0;
        #12;
        model_reset();
        check_all();
        reset_n = 1;
        idle();
        cycle(1, 0, 1, 1, 1);
        chk("serve_entry_state", 32'(state_o), 32'd1);
        chk("serve_entry_cd", 32'(countdown), 32'd3);

        tick(); idle(); tick();
        chk("no_early_release", 32'(state_o), 32'd1);
        tick();
        chk("release_motion", 32'(motion_en), 32'd1);
        chk("release_field", 32'(field_reset), 32'd0);

        cycle(0, 0, 0, 1, 0);
        chk("rpoint_score_r", 32'(score_r), 32'd1);
        chk("rpoint_serve", 32'(serve_right), 32'd0);
        chk("rpoint_state", 32'(state_o), 32'd4);
        idle();
        chk("reserve_cd", 32'(countdown), 32'd3);

        release_ball();
        cycle(0, 0, 1, 0, 1);
        idle();
        release_ball();
        cycle(0, 0, 1, 0, 0);
        idle();
        chk("win_flag_l", 32'(winner_l), 32'd1);
        chk("win_state", 32'(state_o), 32'd5);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("over_hold_l", 32'(score_l), 32'd2);
        cycle(1, 0, 0, 0, 0);
        chk("restart_score_l", 32'(score_l), 32'd0);

        release_ball();
        cycle(0, 0, 0, 1, 0);
        idle();
        release_ball();
        cycle(0, 0, 1, 1, 1);
        chk("double_state", 32'(state_o), 32'd1);
        chk("double_serve", 32'(serve_right), 32'd0);

        release_ball();
        cycle(0, 1, 0, 0, 0);
        chk("pause_state", 32'(state_o), 32'd3);
        cycle(0, 1, 0, 1, 0);
        chk("pause_drop", 32'(score_r), 32'd1);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk("resume_state", 32'(state_o), 32'd2);

        cycle(0, 0, 0, 1, 0);
        idle();
        chk("win_flag_r", 32'(winner_r), 32'd1);
        cycle(1, 0, 0, 0, 0);
        tick();
        chk("pre_abort_cd", 32'(countdown), 32'd2);
        #1;
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        #1;
        reset_n = 1;
        idle();

        for (int i = 0; i < 3000; i++) begin
            bit st, lp, rp, ft;
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            st = ($urandom_range(0, 31) == 0);
            lp = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 9) == 0);
            ft = ($urandom_range(0, 2) == 0);
            cycle(st, pause, lp, rp, ft);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
